// File: rtl/scramble_whitener.sv
// BLE data whitener (x^7+x^4+1 LFSR, seeded from the channel index), one-cycle registered latency.
// Optional feature macro: SCRAMBLE_AUTO_RELOAD_EN reseeds from the stored channel after each packet's last bit.
module scramble_whitener #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                data_in,
    input  logic                                data_in_valid,
    input  logic                                data_in_valid_last,
    output logic                                data_out,
    output logic                                data_out_valid,
    output logic                                data_out_valid_last
);

    // lfsr[i] holds r_i; r6 is the output tap.
    function automatic logic [6:0] seed_of(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

    function automatic logic [6:0] advance(input logic [6:0] r);
        return {r[5], r[4], r[3] ^ r[6], r[2], r[1], r[0], r[6]};
    endfunction

    logic [5:0] ch_low;
    logic [6:0] lfsr;
    logic [6:0] base;
    logic [6:0] lfsr_next;

    assign ch_low = channel_number[5:0];

`ifdef SCRAMBLE_AUTO_RELOAD_EN
    logic [5:0] stored_channel;

    always_ff @(posedge clk) begin
        if (rst)
            stored_channel <= 6'd0;
        else if (channel_number_load)
            stored_channel <= ch_low;
    end
`endif

    // A load coinciding with a valid bit whitens that bit with the fresh seed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        base      = channel_number_load ? seed_of(ch_low) : lfsr;
        lfsr_next = base;
        if (data_in_valid) begin
            lfsr_next = advance(base);
`ifdef SCRAMBLE_AUTO_RELOAD_EN
            if (data_in_valid_last)
                lfsr_next = seed_of(channel_number_load ? ch_low : stored_channel);
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            lfsr                <= seed_of(6'd0);
            data_out            <= 1'b0;
            data_out_valid      <= 1'b0;
            data_out_valid_last <= 1'b0;
        end else begin
            lfsr                <= lfsr_next;
            data_out_valid      <= data_in_valid;
            data_out_valid_last <= data_in_valid & data_in_valid_last;
            if (data_in_valid)
                data_out <= data_in ^ base[6];
        end
    end

endmodule

// File: tb/tb_scramble_whitener.sv
// Self-checking bench for scramble_whitener: bit-level reference model feeding a scoreboard queue,
// anchored by fixed whitening sequences for channels 0 and 37.
module tb_scramble_whitener;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] channel_number;
    logic       channel_number_load;
    logic       data_in;
    logic       data_in_valid;
    logic       data_in_valid_last;
    logic       data_out;
    logic       data_out_valid;
    logic       data_out_valid_last;

    always #5 clk = ~clk;

    scramble_whitener #(.CHANNEL_NUMBER_BIT_WIDTH(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .channel_number      (channel_number),
        .channel_number_load (channel_number_load),
        .data_in             (data_in),
        .data_in_valid       (data_in_valid),
        .data_in_valid_last  (data_in_valid_last),
        .data_out            (data_out),
        .data_out_valid      (data_out_valid),
        .data_out_valid_last (data_out_valid_last)
    );

    typedef struct packed {
        logic valid;
        logic data;
        logic last;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic       held_data = 1'b0;
    bit         m_r[7];
    logic [5:0] m_ch = 6'd0;

    localparam logic [7:0] CH37_ZEROS = 8'b1011_0001; // MSB first in time
    localparam logic [7:0] CH37_ONES  = 8'b0100_1110;
    localparam logic [7:0] CH37_CONT  = 8'b0100_1011; // bits 9..16 of channel 37
    localparam logic [6:0] CH0_ZEROS  = 7'b000_0001;

    function automatic void m_seed(input logic [5:0] ch);
        m_r[0] = 1'b1;
        for (int i = 1; i < 7; i++) m_r[i] = ch[6-i];
    endfunction

    function automatic logic m_whiten(input logic d);
        bit t[7];
        t = m_r;
        for (int i = 1; i < 7; i++) m_r[i] = t[i-1];
        m_r[0] = t[6];
        m_r[4] = t[3] ^ t[6];
        return d ^ t[6];
    endfunction

    // Drive one input cycle, record the model's expectation, advance to the sampling edge.
    task automatic step(input logic r, input logic ld, input logic [5:0] ch,
                        input logic v, input logic d, input logic l);
        exp_t e;
        rst = r; channel_number_load = ld; channel_number = ch;
        data_in_valid = v; data_in = d; data_in_valid_last = l;
        if (r) begin
            e = '{1'b0, 1'b0, 1'b0};
            m_ch = 6'd0;
            m_seed(6'd0);
        end else begin
            if (ld) begin
                m_ch = ch;
                m_seed(ch);
            end
            if (v) begin
                e = '{1'b1, m_whiten(d), l};
`ifdef SCRAMBLE_AUTO_RELOAD_EN
                if (l) m_seed(m_ch);
`endif
            end else begin
                e = '{1'b0, held_data, 1'b0};
            end
        end
        held_data = e.data;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(i < 2, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL reset[%0d] got v/d/l=%b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
        end
    endtask

    task automatic test_ch0_seed();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front(); checks += 2;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL ch0_seed_sb[%0d] got %b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
            if (data_out !== CH0_ZEROS[6-i]) begin
                failures++;
                $display("FAIL ch0_seed_vec[%0d] got %b want %b", i, data_out, CH0_ZEROS[6-i]);
            end
        end
    endtask

    // ones=0: load on its own cycle; ones=1: load coincides with the first bit.
    task automatic test_ch37(input logic ones);
        exp_t       e;
        logic [7:0] vec;
        vec = ones ? CH37_ONES : CH37_ZEROS;
        if (!ones) begin
            step(1'b0, 1'b1, 6'd37, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({data_out_valid, data_out_valid_last} !== {e.valid, e.last}) begin
                failures++;
                $display("FAIL ch37_load_idle got v/l=%b%b want %b%b",
                         data_out_valid, data_out_valid_last, e.valid, e.last);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, ones && i == 0, 6'd37, 1'b1, ones, i == 7);
            e = sb.pop_front(); checks += 2;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL ch37_%0d_sb[%0d] got %b%b%b want %b%b%b", ones, i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
            if (data_out !== vec[7-i]) begin
                failures++;
                $display("FAIL ch37_%0d_vec[%0d] got %b want %b", ones, i, data_out, vec[7-i]);
            end
        end
    endtask

    // Bits every 16 clocks; data_in_valid_last is also waved on idle cycles and must be ignored.
    task automatic test_spaced();
        exp_t e;
        int   n_valid = 0;
        int   n_last  = 0;
        step(1'b0, 1'b1, 6'd37, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'b0, 6'd0, (i % 16) == 0, 1'($urandom_range(0, 1)),
                 (i == 64) || ((i % 16) == 5));
            e = sb.pop_front(); checks++;
            if (data_out_valid === 1'b1) n_valid++;
            if (data_out_valid_last === 1'b1) n_last++;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL spaced[%0d] got %b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
        end
        checks += 2;
        if (n_valid != 5) begin
            failures++;
            $display("FAIL spaced_count got %0d want 5", n_valid);
        end
        if (n_last != 1) begin
            failures++;
            $display("FAIL spaced_last_count got %0d want 1", n_last);
        end
    endtask

    task automatic test_two_packets();
        exp_t       e;
        logic [7:0] vec;
`ifdef SCRAMBLE_AUTO_RELOAD_EN
        vec = CH37_ZEROS;
`else
        vec = CH37_CONT;
`endif
        step(1'b0, 1'b1, 6'd37, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, 6'd0, i != 8 && i != 9, 1'b0, i == 7 || i == 17);
            e = sb.pop_front(); checks++;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL two_pkt_sb[%0d] got %b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
            if (i >= 10) begin
                checks++;
                if (data_out !== vec[17-i]) begin
                    failures++;
                    $display("FAIL two_pkt_vec[%0d] got %b want %b", i - 10, data_out, vec[17-i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [9:0] want;
        want = {CH37_ZEROS[7:5], CH0_ZEROS};
        step(1'b0, 1'b1, 6'd37, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 11; i++) begin
            if (i == 3) step(1'b1, 1'b1, 6'd37, 1'b1, 1'b1, 1'b1);
            else        step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front(); checks += 2;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL rst_mid_sb[%0d] got %b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
            if (i == 3) begin
                if ({data_out_valid, data_out, data_out_valid_last} !== 3'b000) begin
                    failures++;
                    $display("FAIL rst_mid_flush got %b%b%b want 000",
                             data_out_valid, data_out, data_out_valid_last);
                end
            end else if (data_out !== want[(i < 3) ? 9 - i : 10 - i]) begin
                failures++;
                $display("FAIL rst_mid_vec[%0d] got %b want %b", i, data_out,
                         want[(i < 3) ? 9 - i : 10 - i]);
            end
        end
    endtask

    // Random channels, back-to-back bits, occasional idles and loads mid-stream.
    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 120; i++) begin
            step(1'b0, (i % 30) == 0 || $urandom_range(0, 19) == 0, 6'($urandom_range(0, 39)),
                 $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            e = sb.pop_front(); checks++;
            if ({data_out_valid, data_out, data_out_valid_last} !== {e.valid, e.data, e.last}) begin
                failures++;
                $display("FAIL b2b[%0d] got %b%b%b want %b%b%b", i,
                         data_out_valid, data_out, data_out_valid_last, e.valid, e.data, e.last);
            end
        end
    endtask

    initial begin
        rst = 1'b1; channel_number = 6'd0; channel_number_load = 1'b0;
        data_in = 1'b0; data_in_valid = 1'b0; data_in_valid_last = 1'b0;
        m_seed(6'd0);
        @(negedge clk);
        test_reset();
        test_ch0_seed();
        test_ch37(1'b0);
        test_ch37(1'b1);
        test_spaced();
        test_two_packets();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scramble_whitener.md
SCRAMBLE_WHITENER -- requirements
Module: scramble

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, giving the channel index width; only the low 6 bits are used.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1; reset is rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port channel_number, input, CHANNEL_NUMBER_BIT_WIDTH, BLE channel index 0..39.
REQ-005 SHALL have port channel_number_load, input, 1, one-cycle strobe that latches channel_number and reseeds the LFSR.
REQ-006 SHALL have port data_in, input, 1, serial data bit.
REQ-007 SHALL have port data_in_valid, input, 1, qualifies data_in.
REQ-008 SHALL have port data_in_valid_last, input, 1, marks the final bit of a packet; meaningful only with data_in_valid.
REQ-009 SHALL have port data_out, output, 1, whitened bit.
REQ-010 SHALL have port data_out_valid, output, 1, qualifies data_out.
REQ-011 SHALL have port data_out_valid_last, output, 1, marks the final whitened bit.

Function
REQ-012 SHALL implement BLE data whitening with a 7-bit LFSR r0..r6 for polynomial x^7+x^4+1.
REQ-013 SHALL form the seed from channel index ch: r0=1, r1=ch[5], r2=ch[4], r3=ch[3], r4=ch[2], r5=ch[1], r6=ch[0].
REQ-014 SHALL, per valid input bit, compute out = data_in XOR r6, then shift: r0'=r6, r1'=r0, r2'=r1, r3'=r2, r4'=r3 XOR r6, r5'=r4, r6'=r5.
REQ-015 SHALL hold the LFSR whenever data_in_valid=0; there is no back-pressure and a valid bit may arrive on any cycle, including back-to-back.
REQ-016 SHALL register all outputs, with data_out, data_out_valid and data_out_valid_last appearing exactly 1 clock after the input cycle.
REQ-017 SHALL assert data_out_valid_last only together with data_out_valid, for the bit whose input had data_in_valid_last=1.
REQ-018 SHALL, on channel_number_load=1, store channel_number and load the LFSR with its seed.
REQ-019 SHALL, when channel_number_load and data_in_valid coincide, whiten that data bit with the new seed and leave the LFSR at the seed advanced once.
REQ-020 SHALL ignore data_in_valid_last when data_in_valid=0.
REQ-021 SHALL drive data_out_valid low and data_out_valid_last low in every cycle following an input cycle with data_in_valid=0; data_out holds its last value.

Reset
REQ-022 SHALL, while rst=1, drive data_out=0, data_out_valid=0 and data_out_valid_last=0.
REQ-023 SHALL, while rst=1, set the stored channel to 0 and the LFSR to the channel-0 seed (1,0,0,0,0,0,0).
REQ-024 SHALL give rst priority over channel_number_load and data_in_valid, and SHALL discard any bit in flight; rst mid-packet yields no output on the following cycle.

Configuration
REQ-025 SHALL honour the macro SCRAMBLE_AUTO_RELOAD_EN.
REQ-026 SHALL, with SCRAMBLE_AUTO_RELOAD_EN defined, reload the LFSR from the stored channel's seed in the cycle after a bit with data_in_valid_last=1, so each packet restarts whitening without a new load strobe.
REQ-027 SHALL, without SCRAMBLE_AUTO_RELOAD_EN, keep the LFSR running across packets; only channel_number_load or rst reseeds it.

Verification
REQ-028 SHALL cover this case: load channel 37, then 8 valid zero bits -> data_out 1,0,1,1,0,0,0,1, each 1 cycle after its input.
REQ-029 SHALL cover this case: rst, then no load, then 7 valid zero bits -> data_out 0,0,0,0,0,0,1 (channel-0 seed).
REQ-030 SHALL cover this case: load channel 37, then 8 valid one bits -> data_out 0,1,0,0,1,1,1,0 (inverse of REQ-028).
REQ-031 SHALL cover this case: valid bits spaced every 16 clocks with the last flagged -> data_out_valid pulses 1 cycle each, with data_out_valid_last only on the final pulse and the total output count equal to the input count.
REQ-032 SHALL cover this case: two packets on channel 37, each of 8 zero bits, with no reload between -> with SCRAMBLE_AUTO_RELOAD_EN both give 1,0,1,1,0,0,0,1; without it the second continues the sequence.
REQ-033 SHALL cover this case: rst asserted after 3 bits of a packet -> outputs 0 the next cycle, and the following bits use the channel-0 seed.
